sram_multi_fifo: RTL

- Generalised external-SRAM FIFO controller: NCH independent ring-buffer FIFOs in one asynchronous 16-bit SRAM, one word per access.
- Replaces the fixed two-FIFO SRAM controller (CPU-side in, radio-side out) in the link top level.
- Serves any number of producers/consumers (SPI slave, wireless ctrl, future channels) through round-robin arbitration and a req/ack handshake.

---
 rtl/sram_multi_fifo_pkg.sv | 21 ++
 rtl/sram_multi_fifo_if.sv | 27 ++
 rtl/sram_multi_fifo_rr_arbiter.sv | 41 ++++
 rtl/sram_multi_fifo.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/sram_multi_fifo_pkg.sv
// Shared definitions for the multi-channel SRAM FIFO controller:
// access FSM encoding, SRAM strobe timing and channel base addressing.
package sram_multi_fifo_pkg;

  // Access FSM: one idle/arbitration cycle plus two SRAM cycles per word
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC1 = 2'd1;
  localparam logic [1:0] ST_ACC2 = 2'd2;

  // SRAM timing: WE_n pulses low in the first access cycle; the second
  // cycle holds write data after WE_n rises and samples read data
  localparam logic [1:0] ST_WE_LOW = ST_ACC1;
  localparam logic [1:0] ST_COMMIT = ST_ACC2;

  // Channel c owns the address window starting at c << depth_log2
  function automatic int unsigned ch_base(input int unsigned ch,
                                          input int unsigned depth_log2);
    return ch << depth_log2;
  endfunction

endpackage

// File: rtl/sram_multi_fifo_if.sv
// Producer/consumer side of the SRAM FIFO: per-channel req/ack handshakes
// and occupancy status, flattened per channel.
interface sram_multi_fifo_if #(
  parameter int NCH        = 2,
  parameter int DW         = 16,
  parameter int DEPTH_LOG2 = 10
);
  logic [NCH-1:0]                  wr_req;
  logic [NCH*DW-1:0]               wr_data;
  logic [NCH-1:0]                  wr_ack;
  logic [NCH-1:0]                  rd_req;
  logic [NCH*DW-1:0]               rd_data;
  logic [NCH-1:0]                  rd_valid;
  logic [NCH-1:0]                  full;
  logic [NCH-1:0]                  empty;
  logic [NCH*(DEPTH_LOG2+1)-1:0]   count;

  modport master (
    output wr_req, wr_data, rd_req,
    input  wr_ack, rd_data, rd_valid, full, empty, count
  );

  modport slave (
    input  wr_req, wr_data, rd_req,
    output wr_ack, rd_data, rd_valid, full, empty, count
  );
endinterface

// File: rtl/sram_multi_fifo_rr_arbiter.sv
// Round-robin arbiter: searches from one past the last grant, and the
// search start only moves when a grant is actually taken.
module sram_multi_fifo_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;

  // First requester at or after the pointer, wrapping around the ring
  always_comb begin
    int k;
    found       = 1'b0;
    grant_idx_o = '0;
    grant_o     = '0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr_q) + i) % N;
      if (!found && req_i[k]) begin
        found       = 1'b1;
        grant_idx_o = IW'(k);
      end
    end
    grant_o[grant_idx_o] = found;
    ptr_d = (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + IW'(1);
  end

  // Pointer moves past the winner only when the grant is consumed
  always_ff @(posedge clk) begin
    if (rst)                     ptr_q <= '0;
    else if (advance_i && found) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sram_multi_fifo.sv
// NCH independent ring-buffer FIFOs sharing one asynchronous SRAM.
// Each granted access takes IDLE -> ACC1 -> ACC2; channels are served
// round-robin over the ring wr0, rd0, wr1, rd1, ...
module sram_multi_fifo
  import sram_multi_fifo_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int DW         = 16,
  parameter int AW         = 18,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                clk,
  input  logic                rst,
  sram_multi_fifo_if.slave    bus,
  output logic [AW-1:0]       mem_addr,
  inout  wire  [DW-1:0]       Dout,
  output logic                CE_n,
  output logic                OE_n,
  output logic                WE_n,
  output logic                LB_n,
  output logic                UB_n
);

  localparam int N    = 2 * NCH;
  localparam int IW   = $clog2(N);
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNTW = DEPTH_LOG2 + 1;
  localparam logic [CNTW-1:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  if (AW < $clog2(NCH) + DEPTH_LOG2) begin : g_aw_check
    $error("AW too narrow for NCH channels of 2^DEPTH_LOG2 words");
  end

  logic [1:0]            state_q, state_d;
  logic                  is_wr_q;
  logic [CW-1:0]         ch_q;
  logic [AW-1:0]         addr_q;
  logic [DW-1:0]         wdata_q;
  logic [DW-1:0]         rdata_q;
  logic [NCH-1:0]        rd_valid_q;
  logic [DEPTH_LOG2-1:0] wptr_q  [NCH];
  logic [DEPTH_LOG2-1:0] rptr_q  [NCH];
  logic [CNTW-1:0]       count_q [NCH];

  logic [NCH-1:0] full_w, empty_w;
  logic [N-1:0]   elig;
  logic [N-1:0]   grant;
  logic [IW-1:0]  grant_idx;
  logic           grant_vld;
  logic           advance;
  logic [CW-1:0]  gnt_ch;
  logic           gnt_wr;
  logic           in_access;

  // A read whose rd_valid is showing this cycle is masked: its requester
  // still holds rd_req until it sees rd_valid and must not be popped twice.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign full_w[c]   = (count_q[c] == FULL_CNT);
    assign empty_w[c]  = (count_q[c] == '0);
    assign elig[2*c]   = bus.wr_req[c] && !full_w[c];
    assign elig[2*c+1] = bus.rd_req[c] && !empty_w[c] && !rd_valid_q[c];
    assign bus.count[c*CNTW +: CNTW] = count_q[c];
  end

  assign bus.full  = full_w;
  assign bus.empty = empty_w;

  sram_multi_fifo_rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (elig),
    .advance_i   (advance),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign grant_vld = |grant;
  assign advance   = (state_q == ST_IDLE) && grant_vld;
  assign gnt_ch    = CW'(grant_idx >> 1);
  assign gnt_wr    = ~grant_idx[0];

  // Access sequencing: leave IDLE only on a grant, then two SRAM cycles
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_vld) state_d = ST_ACC1;
      ST_ACC1: state_d = ST_ACC2;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers: FSM, granted access, address and read result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      is_wr_q    <= 1'b0;
      ch_q       <= '0;
      addr_q     <= '0;
      rdata_q    <= '0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= '0;
      if (advance) begin
        is_wr_q <= gnt_wr;
        ch_q    <= gnt_ch;
        addr_q  <= AW'(ch_base(32'(gnt_ch), DEPTH_LOG2))
                 + AW'(gnt_wr ? wptr_q[gnt_ch] : rptr_q[gnt_ch]);
      end
      if (state_q == ST_COMMIT && !is_wr_q) begin
        rdata_q          <= Dout;
        rd_valid_q[ch_q] <= 1'b1;
      end
    end
  end

  // Write word captured at grant so the producer may move on after ack
  always_ff @(posedge clk) begin
    if (advance && gnt_wr) wdata_q <= bus.wr_data[gnt_ch*DW +: DW];
  end

  // Pointer and occupancy update on the commit cycle; pointers wrap freely
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        wptr_q[c]  <= '0;
        rptr_q[c]  <= '0;
        count_q[c] <= '0;
      end
    end else if (state_q == ST_COMMIT) begin
      if (is_wr_q) begin
        wptr_q[ch_q]  <= wptr_q[ch_q] + DEPTH_LOG2'(1);
        count_q[ch_q] <= count_q[ch_q] + CNTW'(1);
      end else begin
        rptr_q[ch_q]  <= rptr_q[ch_q] + DEPTH_LOG2'(1);
        count_q[ch_q] <= count_q[ch_q] - CNTW'(1);
      end
    end
  end

  assign in_access    = (state_q == ST_ACC1) || (state_q == ST_ACC2);
  assign bus.wr_ack   = (state_q == ST_COMMIT && is_wr_q) ? (NCH'(1) << ch_q) : '0;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = {NCH{rdata_q}};

  assign mem_addr = addr_q;
  assign CE_n     = ~in_access;
  assign WE_n     = ~((state_q == ST_WE_LOW) && is_wr_q);
  assign OE_n     = ~(in_access && !is_wr_q);
  assign LB_n     = 1'b0;
  assign UB_n     = 1'b0;
  assign Dout     = (in_access && is_wr_q) ? wdata_q : 'z;

endmodule
